cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-003 SHALL: rdy  input  1  global enable; rdy=0 freezes all state.
REQ-004 SHALL: flush  input  1  mispredict flush; discards all buffered results.
REQ-005 SHALL: alu_valid / lsb_valid / bru_valid  input  1 each  requester has result this cycle.
REQ-006 SHALL: alu_tag / lsb_tag / bru_tag  input  4 each  ROB tag of result.
REQ-007 SHALL: alu_data / lsb_data / bru_data  input  32 each  result value.
REQ-008 SHALL: alu_ready / lsb_ready / bru_ready  output  1 each  requester buffer can accept.
REQ-009 SHALL: cdb_valid  output  1  broadcast valid (registered).
REQ-010 SHALL: cdb_tag  output  4  broadcast tag (registered).
REQ-011 SHALL: cdb_data  output  32  broadcast value (registered).
REQ-012 SHALL: cdb_src  output  2  granted source: 0 ALU, 1 LSB, 2 BRU (registered).

Function
REQ-013 SHALL: each requester owns a private 2-entry FIFO of {tag,data}, 2-bit count, 1-bit rd/wr pointers wrapping 1->0.
REQ-014 SHALL: X_ready = (count_X < 2) && rdy, combinational from registered count only.
REQ-015 SHALL: push when X_valid && X_ready; X_valid while not ready is ignored (no write, no error).
REQ-016 SHALL: each cycle with rdy=1, grant at most one non-empty FIFO; pop its head into cdb_* registers, cdb_valid=1.
REQ-017 SHALL: no non-empty FIFO -> cdb_valid=0 next cycle; cdb_tag/cdb_data/cdb_src hold previous values.
REQ-018 SHALL: round-robin: 2-bit last_grant register; search order starts at last_grant+1 (mod 3: 0->1->2->0); last_grant updates only on a grant.
REQ-019 SHALL: latency: result pushed in cycle N broadcast no earlier than cycle N+1 (no bypass from input to cdb).
REQ-020 SHALL: simultaneous push and pop on same FIFO in one cycle: count unchanged, both pointers advance.
REQ-021 SHALL: push on count=1 with pop same cycle is legal; full FIFO (count=2) never pushes, but may pop.
REQ-022 SHALL: flush=1 (rdy=1): all counts and pointers -> 0, cdb_valid -> 0 next cycle, no grant that cycle, pushes that cycle dropped; last_grant unchanged.
REQ-023 SHALL: rdy=0: counts, pointers, last_grant, cdb_* all hold; flush ignored.
REQ-024 SHALL: count never exceeds 2 or underflows below 0.

Reset
REQ-025 SHALL: rst=0 asynchronously sets counts, pointers to 0, last_grant=2 (first search starts at ALU), cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0.
REQ-026 SHALL: reset mid-operation discards all buffered results; X_ready outputs reflect empty FIFOs from first cycle after release (given rdy=1).

Configuration
REQ-027 SHALL: macro CDB_ARB_FIXED_PRIO_EN defined -> fixed priority LSB > ALU > BRU, last_grant unused (still reset, never read).
REQ-028 SHALL: CDB_ARB_FIXED_PRIO_EN undefined -> round-robin per REQ-018; all other behaviour identical in both builds.

Verification
REQ-029 SHALL: reset release, ALU pushes tag 3 data 0x11 at cycle 1 -> cdb_valid=1, tag 3, data 0x11, src 0 at cycle 2; cdb_valid=0 at cycle 3.
REQ-030 SHALL: all three push same cycle (tags 1,2,3), round-robin build -> broadcasts ALU, LSB, BRU on three consecutive cycles; fixed-prio build -> LSB, ALU, BRU.
REQ-031 SHALL: ALU valid every cycle with cdb busy serving LSB/BRU continuously -> alu_ready drops after 2 accepted entries, ALU granted within 3 cycles, no entry lost or duplicated.
REQ-032 SHALL: FIFOs holding 5 entries total, flush=1 -> cdb_valid=0 next cycle, all X_ready=1, no stale tag ever broadcast.
REQ-033 SHALL: rdy=0 for 4 cycles with 2 buffered entries -> cdb_* and X_ready (0) frozen; rdy=1 resumes broadcasting in original order.
REQ-034 SHALL: rst=0 asserted asynchronously mid-broadcast (cdb_valid=1, data 0xDEADBEEF) -> cdb_valid=0, cdb_data=0 immediately, without clock edge.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three 2-deep result FIFOs feeding one registered CDB.
// Define CDB_ARB_FIXED_PRIO_EN for fixed LSB > ALU > BRU priority (default round-robin).
module cdb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        flush,
   input  logic        alu_valid,
   input  logic [3:0]  alu_tag,
   input  logic [31:0] alu_data,
   input  logic        lsb_valid,
   input  logic [3:0]  lsb_tag,
   input  logic [31:0] lsb_data,
   input  logic        bru_valid,
   input  logic [3:0]  bru_tag,
   input  logic [31:0] bru_data,
   output logic        alu_ready,
   output logic        lsb_ready,
   output logic        bru_ready,
   output logic        cdb_valid,
   output logic [3:0]  cdb_tag,
   output logic [31:0] cdb_data,
   output logic [1:0]  cdb_src
);

   logic [1:0]  cnt   [3];
   logic        rp    [3];
   logic        wp    [3];
   logic [3:0]  ftag  [3][2];
   logic [31:0] fdata [3][2];
   logic [1:0]  last_grant;

   logic [2:0]  in_v;
   logic [3:0]  in_tag  [3];
   logic [31:0] in_data [3];
   logic [2:0]  nonempty;
   logic [2:0]  push;
   logic [2:0]  pop;
   logic        gnt_any;
   logic [1:0]  gnt_idx;

   assign in_v       = {bru_valid, lsb_valid, alu_valid};
   assign in_tag[0]  = alu_tag;
   assign in_tag[1]  = lsb_tag;
   assign in_tag[2]  = bru_tag;
   assign in_data[0] = alu_data;
   assign in_data[1] = lsb_data;
   assign in_data[2] = bru_data;

   // Ready depends only on registered occupancy, never on this cycle's pop.
   assign alu_ready = (cnt[0] < 2'd2) && rdy;
   assign lsb_ready = (cnt[1] < 2'd2) && rdy;
   assign bru_ready = (cnt[2] < 2'd2) && rdy;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         nonempty[i] = (cnt[i] != 2'd0);
      end
   end

`ifdef CDB_ARB_FIXED_PRIO_EN
   always_comb begin
      gnt_any = 1'b1;
      gnt_idx = 2'd0;
      if (nonempty[1]) begin
         gnt_idx = 2'd1;
      end else if (nonempty[0]) begin
         gnt_idx = 2'd0;
      end else if (nonempty[2]) begin
         gnt_idx = 2'd2;
      end else begin
         gnt_any = 1'b0;
      end
   end
`else
   function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] k);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, k};
      if (s >= 3'd3) begin
         s = s - 3'd3;
      end
      return s[1:0];
   endfunction

   // Search starts one past the last winner and wraps through all three.
   always_comb begin
      logic [1:0] idx;
      gnt_any = 1'b0;
      gnt_idx = 2'd0;
      idx     = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         idx = rr_idx(last_grant, 2'(k));
         if (!gnt_any && nonempty[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
   end
`endif

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         push[i] = rdy && !flush && in_v[i] && (cnt[i] < 2'd2);
         pop[i]  = rdy && !flush && gnt_any && (gnt_idx == 2'(i));
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (push[i]) begin
            ftag[i][wp[i]]  <= in_tag[i];
            fdata[i][wp[i]] <= in_data[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= 2'd0;
            rp[i]  <= 1'b0;
            wp[i]  <= 1'b0;
         end
         last_grant <= 2'd2;
         cdb_valid  <= 1'b0;
         cdb_tag    <= 4'd0;
         cdb_data   <= 32'd0;
         cdb_src    <= 2'd0;
      end else if (rdy) begin
         if (flush) begin
            for (int i = 0; i < 3; i++) begin
               cnt[i] <= 2'd0;
               rp[i]  <= 1'b0;
               wp[i]  <= 1'b0;
            end
            cdb_valid <= 1'b0;
         end else begin
            for (int i = 0; i < 3; i++) begin
               if (push[i]) begin
                  wp[i] <= ~wp[i];
               end
               if (pop[i]) begin
                  rp[i] <= ~rp[i];
               end
               cnt[i] <= cnt[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            end
            cdb_valid <= gnt_any;
            if (gnt_any) begin
               cdb_tag    <= ftag[gnt_idx][rp[gnt_idx]];
               cdb_data   <= fdata[gnt_idx][rp[gnt_idx]];
               cdb_src    <= gnt_idx;
               last_grant <= gnt_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomised scoreboard bench for cdb_arbiter against a queue-based model.
// Honours CDB_ARB_FIXED_PRIO_EN the same way as the design.
module tb_cdb_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, flush;
   logic        alu_valid, lsb_valid, bru_valid;
   logic [3:0]  alu_tag, lsb_tag, bru_tag;
   logic [31:0] alu_data, lsb_data, bru_data;
   logic        alu_ready, lsb_ready, bru_ready;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic [1:0]  cdb_src;

   typedef struct packed {
      logic [3:0]  tag;
      logic [31:0] data;
   } ent_t;

   typedef struct packed {
      logic        v;
      logic [3:0]  tag;
      logic [31:0] data;
      logic [1:0]  src;
   } obs_t;

   ent_t        mq [3][$];
   obs_t        expq [$];
   obs_t        cur;
   int          last;
   int          npass = 0;
   int          ntot = 0;
   bit          mon_en = 1'b0;
   logic [3:0]  d_tag  [3];
   logic [31:0] d_data [3];

   cdb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .rdy       (rdy),
      .flush     (flush),
      .alu_valid (alu_valid),
      .alu_tag   (alu_tag),
      .alu_data  (alu_data),
      .lsb_valid (lsb_valid),
      .lsb_tag   (lsb_tag),
      .lsb_data  (lsb_data),
      .bru_valid (bru_valid),
      .bru_tag   (bru_tag),
      .bru_data  (bru_data),
      .alu_ready (alu_ready),
      .lsb_ready (lsb_ready),
      .bru_ready (bru_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
   endtask

   // Next winner: first non-empty source in the arbitration order.
   function automatic int pick();
`ifdef CDB_ARB_FIXED_PRIO_EN
      int ord [3] = '{1, 0, 2};
      for (int k = 0; k < 3; k++) begin
         if (mq[ord[k]].size() > 0) return ord[k];
      end
`else
      for (int k = 1; k <= 3; k++) begin
         if (mq[(last + k) % 3].size() > 0) return (last + k) % 3;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) mq[i].delete();
      cur  = '0;
      last = 2;
   endtask

   task automatic rand_payload();
      for (int i = 0; i < 3; i++) begin
         d_tag[i]  = 4'($urandom);
         d_data[i] = $urandom;
      end
   endtask

   // Drive one cycle at the falling edge and predict the next rising edge.
   task automatic step(input bit r, input bit f, input bit [2:0] v);
      int   pre [3];
      int   g;
      ent_t e;
      rdy       = r;
      flush     = f;
      alu_valid = v[0];
      lsb_valid = v[1];
      bru_valid = v[2];
      alu_tag   = d_tag[0];
      lsb_tag   = d_tag[1];
      bru_tag   = d_tag[2];
      alu_data  = d_data[0];
      lsb_data  = d_data[1];
      bru_data  = d_data[2];
      #1;
      chk("alu_ready", 32'(alu_ready), 32'(mq[0].size() < 2 && r));
      chk("lsb_ready", 32'(lsb_ready), 32'(mq[1].size() < 2 && r));
      chk("bru_ready", 32'(bru_ready), 32'(mq[2].size() < 2 && r));
      if (r) begin
         if (f) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            cur.v = 1'b0;
         end else begin
            for (int i = 0; i < 3; i++) pre[i] = mq[i].size();
            g = pick();
            if (g >= 0) begin
               e        = mq[g].pop_front();
               cur.v    = 1'b1;
               cur.tag  = e.tag;
               cur.data = e.data;
               cur.src  = 2'(g);
               last     = g;
            end else begin
               cur.v = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
               if (v[i] && pre[i] < 2) mq[i].push_back({d_tag[i], d_data[i]});
            end
         end
      end
      expq.push_back(cur);
      @(negedge clk);
   endtask

   always begin : monitor
      obs_t e;
      @(posedge clk);
      #1;
      if (mon_en) begin
         if (expq.size() == 0) begin
            ntot++;
            $display("FAIL sb_empty: got cdb_valid %b want a predicted entry", cdb_valid);
         end else begin
            e = expq.pop_front();
            chk("cdb_valid", 32'(cdb_valid), 32'(e.v));
            chk("cdb_tag", 32'(cdb_tag), 32'(e.tag));
            chk("cdb_data", cdb_data, e.data);
            chk("cdb_src", 32'(cdb_src), 32'(e.src));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b0;
      rdy   = 1'b1;
      flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         d_tag[i]  = '0;
         d_data[i] = '0;
      end
      alu_valid = 1'b0; lsb_valid = 1'b0; bru_valid = 1'b0;
      alu_tag = '0; lsb_tag = '0; bru_tag = '0;
      alu_data = '0; lsb_data = '0; bru_data = '0;
      model_reset();
      #1;
      chk("rst_valid", 32'(cdb_valid), 32'd0);
      chk("rst_tag", 32'(cdb_tag), 32'd0);
      chk("rst_data", cdb_data, 32'd0);
      chk("rst_src", 32'(cdb_src), 32'd0);
      @(negedge clk);
      rst    = 1'b1;
      mon_en = 1'b1;

      // Single ALU result, then idle.
      d_tag[0] = 4'd3; d_data[0] = 32'h11;
      step(1, 0, 3'b001);
      repeat (3) step(1, 0, 3'b000);

      // All three at once.
      for (int i = 0; i < 3; i++) begin
         d_tag[i]  = 4'(i + 1);
         d_data[i] = 32'hA0 + 32'(i);
      end
      step(1, 0, 3'b111);
      repeat (4) step(1, 0, 3'b000);

      // Saturate every source so the CDB is busy every cycle.
      repeat (20) begin
         rand_payload();
         step(1, 0, 3'b111);
      end
      repeat (6) step(1, 0, 3'b000);

      // Build five buffered entries, then flush.
      rand_payload(); step(1, 0, 3'b111);
      rand_payload(); step(1, 0, 3'b111);
      rand_payload(); step(1, 1, 3'b111);
      repeat (3) step(1, 0, 3'b000);

      // Freeze with data in flight, then resume.
      rand_payload(); step(1, 0, 3'b011);
      rand_payload(); step(1, 0, 3'b001);
      rand_payload();
      repeat (4) step(0, 1, 3'b111);
      repeat (5) step(1, 0, 3'b000);

      // Asynchronous reset in the middle of a broadcast.
      d_tag[0] = 4'd7; d_data[0] = 32'hDEADBEEF;
      step(1, 0, 3'b001);
      rand_payload();
      step(1, 0, 3'b011);
      chk("pre_rst_valid", 32'(cdb_valid), 32'(cur.v));
      chk("pre_rst_data", cdb_data, cur.data);
      mon_en = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("arst_valid", 32'(cdb_valid), 32'd0);
      chk("arst_data", cdb_data, 32'd0);
      chk("arst_tag", 32'(cdb_tag), 32'd0);
      chk("arst_src", 32'(cdb_src), 32'd0);
      model_reset();
      @(negedge clk);
      rst    = 1'b1;
      mon_en = 1'b1;
      repeat (2) step(1, 0, 3'b000);

      // Random traffic.
      repeat (3000) begin
         rand_payload();
         step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 3'($urandom));
      end
      repeat (8) step(1, 0, 3'b000);
      #2;
      chk("sb_drained", 32'(expq.size()), 32'd0);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
